// File: rtl/backend_types.sv
// Shared backend types: branch tag count and the mask/tag types derived from it.
package backend_types;

  localparam int BRANCH_TAGS = 4;

  typedef logic [BRANCH_TAGS-1:0]         branch_mask_t;
  typedef logic [$clog2(BRANCH_TAGS)-1:0] branch_tag_t;

endpackage

// File: rtl/brb_itf.sv
// Branch resolution broadcast bundle: one producer (rsp) drives clean/kill
// notifications to every speculative buffer (req).
interface brb_itf #(
  parameter int NUM_TAGS = backend_types::BRANCH_TAGS
);

  logic                        broadcast;
  logic [$clog2(NUM_TAGS)-1:0] tag;
  logic                        clean;
  logic                        kill;

  modport rsp (output broadcast, tag, clean, kill);
  modport req (input  broadcast, tag, clean, kill);

endinterface

// File: rtl/free_tag_picker.sv
// Lowest-index priority encoder over the free (not valid) tags.
module free_tag_picker #(
  parameter int NUM_TAGS  = backend_types::BRANCH_TAGS,
  parameter int TAG_WIDTH = $clog2(NUM_TAGS)
) (
  input  logic [NUM_TAGS-1:0]  valid,
  output logic [TAG_WIDTH-1:0] idx,
  output logic                 found
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        idx   = TAG_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/brb_controller.sv
// Branch tag allocator and resolution broadcaster. Hands out the lowest free
// tag to dispatch, records which older tags each branch depends on, and turns
// branch-unit resolutions into a registered one-cycle clean/kill broadcast.
module brb_controller
  import backend_types::*;
#(
  parameter int NUM_TAGS  = BRANCH_TAGS,
  parameter int TAG_WIDTH = $clog2(NUM_TAGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_ready,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic [NUM_TAGS-1:0]  cur_mask,
  input  logic                 resolve_valid,
  input  logic [TAG_WIDTH-1:0] resolve_tag,
  input  logic                 resolve_mispredict,
  brb_itf.rsp                  brif
);

  logic [NUM_TAGS-1:0]  valid;
  logic [NUM_TAGS-1:0]  valid_n;
  logic [NUM_TAGS-1:0]  dep_mask [NUM_TAGS];
  logic [NUM_TAGS-1:0]  dep_n    [NUM_TAGS];

  logic [TAG_WIDTH-1:0] free_idx;
  logic                 free_found;

  logic                 accepted;
  logic                 clean_now;
  logic                 kill_now;
  logic                 grant;
  logic [NUM_TAGS-1:0]  clean_oh;

  logic                 bcast_vld_p1;
  logic [TAG_WIDTH-1:0] bcast_tag_p1;
  logic                 bcast_clean_p1;
  logic                 bcast_kill_p1;

  free_tag_picker #(
    .NUM_TAGS  (NUM_TAGS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pick (
    .valid (valid),
    .idx   (free_idx),
    .found (free_found)
  );

  // Resolutions against tags that are no longer live (e.g. already swept by
  // an older kill) are silently dropped.
  assign accepted  = resolve_valid & valid[resolve_tag];
  assign clean_now = accepted & ~resolve_mispredict;
  assign kill_now  = accepted &  resolve_mispredict;
  assign clean_oh  = clean_now ? (NUM_TAGS'(1) << resolve_tag) : '0;

  // A kill blocks allocation for its cycle so a new branch never captures
  // a mask that includes tags about to be flushed.
  assign alloc_ready = free_found & ~kill_now;
  assign alloc_tag   = free_idx;
  assign grant       = alloc_req & alloc_ready;
  assign cur_mask    = valid;

  // Next-state for tag liveness and dependency masks.
  always_comb begin
    valid_n = valid;
    dep_n   = dep_mask;
    if (accepted) begin
      valid_n[resolve_tag] = 1'b0;
      for (int j = 0; j < NUM_TAGS; j++) begin
        dep_n[j][resolve_tag] = 1'b0;
      end
    end
    if (kill_now) begin
      for (int j = 0; j < NUM_TAGS; j++) begin
        if (dep_mask[j][resolve_tag]) begin
          valid_n[j] = 1'b0;
        end
      end
    end
    if (grant) begin
      valid_n[free_idx] = 1'b1;
      dep_n[free_idx]   = valid & ~clean_oh;
    end
  end

  // Tag state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      dep_mask <= '{default: '0};
    end else begin
      valid    <= valid_n;
      dep_mask <= dep_n;
    end
  end

  // Stage p1: registered broadcast of the resolution accepted last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcast_vld_p1   <= 1'b0;
      bcast_tag_p1   <= '0;
      bcast_clean_p1 <= 1'b0;
      bcast_kill_p1  <= 1'b0;
    end else begin
      bcast_vld_p1   <= accepted;
      bcast_clean_p1 <= clean_now;
      bcast_kill_p1  <= kill_now;
      if (accepted) begin
        bcast_tag_p1 <= resolve_tag;
      end
    end
  end

  assign brif.broadcast = bcast_vld_p1;
  assign brif.tag       = bcast_tag_p1;
  assign brif.clean     = bcast_clean_p1;
  assign brif.kill      = bcast_kill_p1;

endmodule

// File: doc/brb_controller.md
Name: brb_controller

Overview:
- Producer/responder end of brb_itf: allocates branch tags to dispatching branches and tracks which older branches each tag depends on.
- Accepts resolution results from the branch execution unit and broadcasts clean (correct prediction) or kill (mispredict) to every speculative buffer holding brb_itf.req.
- Sits in the frontend beside dispatch; its output mask is attached to every dispatched instruction's branch_mask.

Parameters:
- NUM_TAGS, default BRANCH_TAGS (4): number of in-flight branch tags and width of every branch mask.
- TAG_WIDTH, default $clog2(NUM_TAGS): width of a tag index.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- alloc_req  input  1  dispatch requests a tag for a branch this cycle
- alloc_ready  output  1  a tag can be granted this cycle (combinational)
- alloc_tag  output  TAG_WIDTH  tag granted when alloc_req & alloc_ready
- cur_mask  output  NUM_TAGS  mask of all outstanding tags, attached to dispatched instructions
- resolve_valid  input  1  branch unit resolves a branch this cycle
- resolve_tag  input  TAG_WIDTH  tag being resolved
- resolve_mispredict  input  1  1 = kill, 0 = clean
- brif  brb_itf.rsp  modport  drives broadcast, tag, clean, kill

Behaviour:
- State:
  - valid[NUM_TAGS]: tag allocated.
  - dep_mask[NUM_TAGS][NUM_TAGS]: outstanding tags older than the tag, captured at allocation.
  - cur_mask: equals the OR of one-hot(i) over all valid i.
- Reset: all valid = 0, dep_mask = 0, cur_mask = 0; brif.broadcast = clean = kill = 0, brif.tag = 0; alloc_ready = 1 after reset.
- Allocation:
  - alloc_tag is the lowest-index tag with valid = 0.
  - alloc_ready = (any tag free) & ~kill_now, where kill_now = resolve_valid & resolve_mispredict & valid[resolve_tag].
  - On alloc_req & alloc_ready, at the clock edge: valid[t] <= 1; dep_mask[t] <= cur_mask, with the bit of any tag cleaned this cycle removed.
  - alloc_req with alloc_ready = 0 is dropped. Dispatch must hold the request and stall.
- Resolution acceptance: resolve_valid with valid[resolve_tag] = 0 is ignored. This covers a tag already freed by an older kill. No broadcast is generated for it.
- Clean (accepted, mispredict = 0), at the edge:
  - valid[tag] <= 0.
  - Clear bit tag in every dep_mask entry.
  - Clear bit tag in cur_mask.
- Kill (accepted, mispredict = 1), at the edge:
  - valid[tag] <= 0.
  - valid[j] <= 0 for every j with dep_mask[j][tag] = 1 (all younger branches).
  - cur_mask recomputed from the surviving valid bits.
  - Any allocation is blocked that cycle (alloc_ready = 0).
- Broadcast latency: exactly 1 cycle, registered.
  - A resolution accepted at edge N drives brif.broadcast = 1, brif.tag = resolve_tag, and clean/kill at cycle N+1, for one cycle only.
  - clean and kill are mutually exclusive. Both are 0 whenever broadcast = 0.
- Throughput: one resolution and one allocation per cycle; resolutions back-to-back each cycle are supported.
- Freed-tag reuse: a tag freed at edge N may be allocated in cycle N+1, i.e. the same cycle its broadcast is visible.
  - Consumers see broadcast for the old tag while the new instance's mask bit is being set.
  - Consumers act on their registered masks, so this is safe; verification must cover it.
- Full: all valid = 1 -> alloc_ready = 0. A clean in that same cycle does not make alloc_ready = 1 until the next cycle (no same-cycle bypass).
- Reset mid-operation: all state cleared at the edge and any pending broadcast is dropped (broadcast = 0 next cycle).

Decomposition:
- backend_types gets:
  - constant BRANCH_TAGS;
  - typedef branch_mask_t (logic [BRANCH_TAGS-1:0]);
  - typedef branch_tag_t (logic [$clog2(BRANCH_TAGS)-1:0]).
- brb_itf gains the rsp modport (outputs broadcast, tag, clean, kill).
- One sub-module, free_tag_picker: parameterised lowest-index priority encoder over ~valid, outputs index and found.

Test Plan:
- Reset, then 4 back-to-back allocs -> alloc_tag 0,1,2,3; cur_mask 0001, 0011, 0111, 1111; alloc_ready = 0 after the 4th.
- Tags 0-2 allocated; clean tag 1 -> next cycle broadcast = 1, tag = 1, clean = 1; cur_mask = 0101; dep_mask[2] = 0001; next alloc returns tag 1.
- Tags 0-3 allocated in order; kill tag 1 -> broadcast tag = 1, kill = 1; cur_mask = 0001; tags 2 and 3 freed; next alloc returns 1.
- Kill tag 2 and alloc_req in the same cycle -> alloc_ready = 0, no grant; resolve of tag 3 in the following cycle ignored (no broadcast).
- Clean tag 0 while allocating tag 2 in the same cycle (tags 0,1 outstanding) -> dep_mask[2] = 0010, cur_mask = 0110, broadcast clean tag 0 next cycle.
- Resolutions on 3 consecutive cycles (clean 0, clean 1, kill 2) -> 3 consecutive single-cycle broadcasts with the matching tag and clean/kill; assert reset during the 2nd -> no further broadcasts, cur_mask = 0.
